// File: rtl/pangya_pkg.sv
// Shared encodings for the Pangya attack-phase judge: FSM states, grades,
// the game-state code that arms the judge and screen/flash geometry.
package pangya_pkg;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_ARMED = 3'd1,
      ST_LOCK  = 3'd2,
      ST_SCORE = 3'd3,
      ST_MISS  = 3'd4,
      ST_SHOW  = 3'd5,
      ST_DONE  = 3'd6,
      ST_WAIT  = 3'd7
   } judge_state_e;

   localparam logic [2:0] ATTACK_STATE_CODE = 3'b100;

   localparam logic [1:0] GRADE_MISS    = 2'd0;
   localparam logic [1:0] GRADE_OK      = 2'd1;
   localparam logic [1:0] GRADE_GOOD    = 2'd2;
   localparam logic [1:0] GRADE_PERFECT = 2'd3;

   localparam logic [9:0] SCREEN_X_LAST = 10'd639;
   localparam logic [9:0] SCREEN_Y_LAST = 10'd479;

   localparam logic [9:0] FLASH_LEFT  = 10'd8;
   localparam logic [9:0] FLASH_RIGHT = 10'd12;
   localparam logic [9:0] FLASH_Y_TOP = 10'd282;
   localparam logic [9:0] FLASH_Y_BOT = 10'd328;

endpackage

// File: rtl/pangya_judge_btn_sync_edge.sv
// Brings the asynchronous attack button into the Pclk domain and turns each
// rising edge into a single-cycle press pulse.
module btn_sync_edge (
   input  logic Pclk,
   input  logic rst_n,
   input  logic btn_i,
   output logic press_o
);

   logic sync1_q;
   logic sync2_q;
   logic prev_q;

   always_ff @(posedge Pclk or negedge rst_n) begin
      if (!rst_n) begin
         sync1_q <= 1'b0;
         sync2_q <= 1'b0;
         prev_q  <= 1'b0;
      end else begin
         sync1_q <= btn_i;
         sync2_q <= sync1_q;
         prev_q  <= sync2_q;
      end
   end

   assign press_o = sync2_q & ~prev_q;

endmodule

// File: rtl/pangya_judge.sv
// Attack-phase timing judge: waits for the attack press, freezes and grades the
// tab position, shows a hit flash for a number of frames, then strobes the result.
module pangya_judge
   import pangya_pkg::*;
#(
   parameter int unsigned CENTER_X       = 300,
   parameter int unsigned PERFECT_W      = 4,
   parameter int unsigned GOOD_W         = 20,
   parameter int unsigned OK_W           = 60,
   parameter logic [7:0]  MAX_DMG        = 8'd40,
   parameter int unsigned TIMEOUT_FRAMES = 180,
   parameter int unsigned SHOW_FRAMES    = 30,
   parameter logic [2:0]  ATTACK_STATE   = ATTACK_STATE_CODE
) (
   input  logic       Pclk,
   input  logic       rst_n,
   input  logic [9:0] xx,
   input  logic [9:0] yy,
   input  logic       aactive,
   input  logic [2:0] state,
   input  logic [9:0] tab_x,
   input  logic       btn_attack,
   output logic       tab_freeze,
   output logic       hitflashOn,
   output logic       hit_valid,
   output logic [1:0] grade,
   output logic [7:0] damage,
   output logic       judge_busy
);

   judge_state_e state_q, state_d;
   logic [15:0]  timeoutCnt_q, timeoutCnt_d;
   logic [15:0]  frameCnt_q, frameCnt_d;
   logic [9:0]   lx_q, lx_d;
   logic [1:0]   grade_q, grade_d;
   logic [7:0]   damage_q, damage_d;
   logic         flash_q, flash_d;

   logic         press;
   logic         frameTick;
   logic         inAttack;
   logic signed [10:0] diff;
   logic signed [10:0] negDiff;
   logic [9:0]   dx;
   logic [1:0]   scoreGrade;
   logic [7:0]   scoreDamage;
   logic [9:0]   flashLo;
   logic [10:0]  hiSum;
   logic [9:0]   flashHi;

   btn_sync_edge uSync (
      .Pclk    (Pclk),
      .rst_n   (rst_n),
      .btn_i   (btn_attack),
      .press_o (press)
   );

   assign frameTick = (xx == SCREEN_X_LAST) && (yy == SCREEN_Y_LAST);
   assign inAttack  = (state == ATTACK_STATE);

   // Signed distance of the frozen tab from the bar centre, folded to a magnitude.
   always_comb begin
      diff        = $signed({1'b0, lx_q}) - $signed(11'(CENTER_X));
      negDiff     = -diff;
      dx          = diff[10] ? negDiff[9:0] : diff[9:0];
      scoreGrade  = GRADE_MISS;
      scoreDamage = 8'd0;
      if (dx <= 10'(PERFECT_W)) begin
         scoreGrade  = GRADE_PERFECT;
         scoreDamage = MAX_DMG;
      end else if (dx <= 10'(GOOD_W)) begin
         scoreGrade  = GRADE_GOOD;
         scoreDamage = MAX_DMG >> 1;
      end else if (dx <= 10'(OK_W)) begin
         scoreGrade  = GRADE_OK;
         scoreDamage = MAX_DMG >> 2;
      end
   end

   // Flash rectangle is clipped to the visible screen instead of wrapping.
   always_comb begin
      flashLo = (lx_q < FLASH_LEFT) ? 10'd0 : (lx_q - FLASH_LEFT);
      hiSum   = {1'b0, lx_q} + {1'b0, FLASH_RIGHT};
      flashHi = (hiSum > {1'b0, SCREEN_X_LAST}) ? SCREEN_X_LAST : hiSum[9:0];
      flash_d = aactive && (state_q == ST_SHOW) && inAttack &&
                (xx >= flashLo) && (xx <= flashHi) &&
                (yy >= FLASH_Y_TOP) && (yy <= FLASH_Y_BOT);
   end

   always_comb begin
      state_d      = state_q;
      timeoutCnt_d = timeoutCnt_q;
      frameCnt_d   = frameCnt_q;
      lx_d         = lx_q;
      grade_d      = grade_q;
      damage_d     = damage_q;
      unique case (state_q)
         ST_IDLE: begin
            if (inAttack) begin
               state_d      = ST_ARMED;
               timeoutCnt_d = 16'd0;
            end
         end
         ST_ARMED: begin
            // A press on the terminal timeout tick still counts as a hit.
            if (!inAttack) begin
               state_d = ST_IDLE;
            end else if (press) begin
               state_d = ST_LOCK;
            end else if (frameTick) begin
               timeoutCnt_d = timeoutCnt_q + 16'd1;
               if (timeoutCnt_q == 16'(TIMEOUT_FRAMES - 1)) begin
                  state_d = ST_MISS;
               end
            end
         end
         ST_LOCK: begin
            lx_d    = tab_x;
            state_d = inAttack ? ST_SCORE : ST_IDLE;
         end
         ST_SCORE: begin
            if (!inAttack) begin
               state_d = ST_IDLE;
            end else begin
               grade_d    = scoreGrade;
               damage_d   = scoreDamage;
               frameCnt_d = 16'd0;
               state_d    = ST_SHOW;
            end
         end
         ST_MISS: begin
            if (!inAttack) begin
               state_d = ST_IDLE;
            end else begin
               grade_d    = GRADE_MISS;
               damage_d   = 8'd0;
               frameCnt_d = 16'd0;
               state_d    = ST_SHOW;
            end
         end
         ST_SHOW: begin
            if (!inAttack) begin
               state_d = ST_IDLE;
            end else if (frameTick) begin
               frameCnt_d = frameCnt_q + 16'd1;
               if (frameCnt_q == 16'(SHOW_FRAMES - 1)) begin
                  state_d = ST_DONE;
               end
            end
         end
         ST_DONE: begin
            state_d = ST_WAIT;
         end
         ST_WAIT: begin
            if (!inAttack) begin
               state_d = ST_IDLE;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge Pclk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= ST_IDLE;
         timeoutCnt_q <= 16'd0;
         frameCnt_q   <= 16'd0;
         lx_q         <= 10'd0;
         grade_q      <= GRADE_MISS;
         damage_q     <= 8'd0;
         flash_q      <= 1'b0;
      end else begin
         state_q      <= state_d;
         timeoutCnt_q <= timeoutCnt_d;
         frameCnt_q   <= frameCnt_d;
         lx_q         <= lx_d;
         grade_q      <= grade_d;
         damage_q     <= damage_d;
         flash_q      <= flash_d;
      end
   end

   assign tab_freeze = (state_q == ST_LOCK) || (state_q == ST_SCORE) ||
                       (state_q == ST_MISS) || (state_q == ST_SHOW)  ||
                       (state_q == ST_DONE) || (state_q == ST_WAIT);
   assign judge_busy = (state_q != ST_IDLE) && (state_q != ST_WAIT);
   assign hit_valid  = (state_q == ST_DONE);
   assign hitflashOn = flash_q;
   assign grade      = grade_q;
   assign damage     = damage_q;

endmodule
